// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared constants, mux encodings and CC types for the LC-3 register file
package lc3_pkg;

  localparam int DATA_W     = 16;
  localparam int NREGS      = 8;
  localparam int REG_ADDR_W = 3;

  localparam logic [REG_ADDR_W-1:0] R7_ADDR   = 3'd7;
  localparam logic [2:0]            NZP_RESET = 3'b010;

  localparam logic DRMUX_IR     = 1'b0;
  localparam logic DRMUX_R7     = 1'b1;
  localparam logic SR1MUX_IR119 = 1'b0;
  localparam logic SR1MUX_IR86  = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  function automatic nzp_t cc_from_bus(input logic [DATA_W-1:0] bus);
    nzp_t cc;
    cc.n = bus[DATA_W-1];
    cc.z = (bus == '0);
    cc.p = !bus[DATA_W-1] && (bus != '0);
    return cc;
  endfunction

endpackage

// File: rtl/lc3_nzp_ben.sv
// rtl/lc3_nzp_ben.sv - condition-code and branch-enable registers
module lc3_nzp_ben
  import lc3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_cc,
  input  logic              ld_ben,
  input  logic [2:0]        ir_cc,
  output nzp_t              nzp,
  output logic              ben
);

  // BEN samples the NZP held before this edge, so a same-edge LD_CC is not seen until later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzp <= nzp_t'(NZP_RESET);
      ben <= 1'b0;
    end else begin
      if (ld_cc) begin
        nzp <= cc_from_bus(bus);
      end
      if (ld_ben) begin
        ben <= (ir_cc[2] & nzp.n) | (ir_cc[1] & nzp.z) | (ir_cc[0] & nzp.p);
      end
    end
  end

endmodule

// File: rtl/lc3_reg_file.sv
// rtl/lc3_reg_file.sv - LC-3 GPR file with operand decode, SEXT imm5 and CC/BEN state
module lc3_reg_file
  import lc3_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] BUS,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  output logic [DATA_W-1:0] SEXT_4,
  output logic              SR2MUX,
  output logic              N,
  output logic              Z,
  output logic              P,
  output logic              BEN
);

  logic [DATA_W-1:0]     regs [NREGS];
  logic [REG_ADDR_W-1:0] dr;
  logic [REG_ADDR_W-1:0] sr1;
  logic [REG_ADDR_W-1:0] sr2;
  nzp_t                  nzp;

  // Opcode bits are decoded by the control unit, not here.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, IR[15:12]};

  assign dr  = (DRMUX == DRMUX_R7) ? R7_ADDR : IR[11:9];
  assign sr1 = (SR1MUX == SR1MUX_IR86) ? IR[8:6] : IR[11:9];
  assign sr2 = IR[2:0];

  // Reads see only committed state; a same-cycle write appears after the edge.
  assign SR1_OUT = regs[sr1];
  assign SR2_OUT = regs[sr2];
  assign SEXT_4  = {{(DATA_W-5){IR[4]}}, IR[4:0]};
  assign SR2MUX  = IR[5];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (LD_REG) begin
      regs[dr] <= BUS;
    end
  end

  lc3_nzp_ben u_nzp_ben (
    .clk    (Clk),
    .rst    (Reset),
    .bus    (BUS),
    .ld_cc  (LD_CC),
    .ld_ben (LD_BEN),
    .ir_cc  (IR[11:9]),
    .nzp    (nzp),
    .ben    (BEN)
  );

  assign N = nzp.n;
  assign Z = nzp.z;
  assign P = nzp.p;

endmodule
